mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single multi-cycle unified memory between the I-cache and D-cache miss handlers and sequences each 8-word block fill.
- Accepts D-cache write-through stores, picks one requester, and drives the memory address/enable stream.
- Steers returning words into the owning cache with a word index, then writes that cache's tag.
- Sits between both caches and main memory; its per-cache stall outputs freeze the pipeline.

Parameters:
- MEM_LATENCY, 4, cycles from a read's mem_en to its mem_data_valid (fixed, pipelined, one read accepted per cycle).
- WORDS, 8, 16-bit words per cache block (block = 16 bytes).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_miss  in  1  I-cache miss pending.
- i_miss_addr  in  16  I-cache missing byte address.
- d_miss  in  1  D-cache miss pending.
- d_miss_addr  in  16  D-cache missing byte address.
- d_wr_req  in  1  D-cache write-through store pending.
- d_wr_addr  in  16  store byte address.
- d_wr_data  in  16  store data.
- mem_en  out  1  memory access enable.
- mem_wr  out  1  1 = write, 0 = read.
- mem_addr  out  16  memory byte address.
- mem_wdata  out  16  memory write data.
- mem_data_valid  in  1  read data valid.
- mem_rdata  in  16  read data.
- i_fill_we, d_fill_we  out  1 each  data-array write enable per cache.
- fill_word  out  3  word index within block.
- fill_data  out  16  word to write (equals mem_rdata).
- i_tag_we, d_tag_we  out  1 each  tag/valid write, one-cycle pulse.
- i_stall, d_stall  out  1 each  requester is busy.
- d_wr_ack  out  1  store accepted, one-cycle pulse.

Behaviour:
- States are DRAIN, IDLE, FILL_I, FILL_D and WRITE.
- Reset enters DRAIN with all counters 0. Every output is 0 while rst_n is low.
- DRAIN lasts MEM_LATENCY cycles, then the block moves to IDLE. This drains reads in flight before reset, and mem_data_valid is ignored in DRAIN.
- IDLE priority, evaluated each cycle: d_wr_req > d_miss > i_miss.
  - On a grant, the base is latched as miss_addr & 16'hFFF0.
  - The state moves to WRITE, FILL_D or FILL_I on the next edge. No memory access is issued in IDLE.
- WRITE lasts one cycle.
  - mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data.
  - d_wr_ack=1 that cycle, then return to IDLE.
- FILL issue side:
  - The issue counter ic runs 0..7.
  - For each cycle with ic<8: mem_en=1, mem_wr=0, mem_addr = base | {ic,1'b0}. This gives 8 consecutive cycles of reads.
  - mem_en=0 once ic reaches 8.
- FILL receive side:
  - The receive counter rc runs 0..7.
  - In each cycle where mem_data_valid=1, the owner's fill_we=1, fill_word=rc and fill_data=mem_rdata, and rc increments.
- Completion: on the valid with rc=7, the owner's tag_we=1 in the same cycle. The next state is IDLE and the counters clear.
- Fill latency: grant seen at edge T, reads at T+1..T+8, data at T+1+L..T+8+L, tag pulse at T+8+L, IDLE at T+9+L.
- Stall rules:
  - i_stall = i_miss & ~i_tag_we.
  - d_stall = (d_miss & ~d_tag_we) | (d_wr_req & ~d_wr_ack).
  - Stall is asserted even while the other requester owns memory.
- The fill/tag outputs for the non-owner stay 0. fill_word and fill_data are 0 when no fill_we is active.
- Boundary cases:
  - mem_data_valid outside FILL is ignored, and a valid after rc=7 is ignored.
  - A request dropped mid-fill does not abort the fill; it runs to completion, including the tag write.
  - New requests during FILL or WRITE are not sampled until IDLE.
  - Simultaneous d_miss and i_miss: D is served first and i_stall stays high throughout, then I is granted from the next IDLE cycle.
  - Reset asserted mid-fill: immediate clear, no tag write, then DRAIN.
- Address arithmetic is OR into the aligned base, so there is no carry and no wrap past 0xFFFF.

Test Plan:
- Reset with rst_n low: all outputs 0. Release: DRAIN for 4 cycles, then the first grant is possible on cycle 5.
- i_miss with i_miss_addr=0x1236, L=4:
  - mem_addr 0x1230,0x1232,…,0x123E on 8 consecutive cycles.
  - i_fill_we with fill_word 0..7 carrying mem_rdata.
  - i_tag_we with word 7; i_stall drops that cycle.
- d_miss and i_miss rise together (0x4008 / 0x0010):
  - The D fill of 0x4000..0x400E completes with d_tag_we.
  - Then the I fill of 0x0010..0x001E runs; i_stall is high for the whole span; no i_fill_we during the D fill.
- d_wr_req (0x8002, 0xBEEF) together with i_miss: one WRITE cycle with mem_wr=1 and d_wr_ack=1, then the I fill starts.
- rst_n pulsed low after 3 returned words:
  - Outputs clear and no tag write occurs.
  - Stale mem_data_valid pulses during DRAIN produce no fill_we.
  - A re-issued miss refills from word 0.
- Spurious mem_data_valid in IDLE, and i_miss deasserted mid-fill: no fill_we in IDLE; the fill still completes with i_tag_we.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Memory-side bus between the cache arbiter and the unified main memory.
//   mem_en / mem_wr      : access strobe, 1 = write, 0 = read
//   mem_addr / mem_wdata : byte address and store data
//   mem_data_valid       : read data valid, fixed latency after mem_en
//   mem_rdata            : returned read data
// modport master : arbiter side (drives the request stream)
// modport slave  : memory side  (returns read data)
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_data_valid;
  logic [15:0] mem_rdata;

  modport master (
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_data_valid, mem_rdata
  );

  modport slave (
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_data_valid, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one pipelined, fixed-latency memory between the I-cache and D-cache
// miss handlers. Serves D-cache write-through stores (single WRITE cycle) and
// sequences WORDS-word block fills, steering returned words into the owning
// cache and pulsing that cache's tag write on the last word.
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   i_miss, i_miss_addr          : I-cache miss request and byte address
//   d_miss, d_miss_addr          : D-cache miss request and byte address
//   d_wr_req, d_wr_addr/data     : D-cache write-through store
//   mem (master)                 : memory request / read-return bus
//   i_fill_we, d_fill_we         : data-array write enable per cache
//   fill_word, fill_data         : word index in block and word value
//   i_tag_we, d_tag_we           : one-cycle tag/valid write pulse
//   i_stall, d_stall             : requester still waiting
//   d_wr_ack                     : store accepted (one-cycle pulse)
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int MEM_LATENCY = 4,
  parameter int WORDS       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  input  logic        d_wr_req,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  mem_arbiter_if.master mem,
  output logic        i_fill_we,
  output logic        d_fill_we,
  output logic [2:0]  fill_word,
  output logic [15:0] fill_data,
  output logic        i_tag_we,
  output logic        d_tag_we,
  output logic        i_stall,
  output logic        d_stall,
  output logic        d_wr_ack
);

  localparam int WW = $clog2(WORDS);          // word-index width
  localparam int IW = WW + 1;                 // issue counter must reach WORDS
  localparam int DW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  localparam logic [WW-1:0] LAST_WORD  = WW'(WORDS - 1);
  localparam logic [IW-1:0] ISSUE_END  = IW'(WORDS);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(MEM_LATENCY - 1);
  // Block-aligned base: clear the byte-offset bits of a 2-byte-word block.
  localparam logic [15:0]   BLK_MASK   = ~16'(WORDS * 2 - 1);

  typedef enum logic [2:0] {
    DRAIN  = 3'd0,
    IDLE   = 3'd1,
    FILL_I = 3'd2,
    FILL_D = 3'd3,
    WRITE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ic_q, ic_d;     // reads issued in the current fill
  logic [WW-1:0] rc_q, rc_d;     // words received in the current fill
  logic [DW-1:0] dc_q, dc_d;     // cycles spent in DRAIN
  logic [15:0]   base_q, base_d; // aligned block base of the current fill

  logic          in_fill;
  logic          fill_hit;
  logic [15:0]   issue_off;

  assign in_fill   = (state_q == FILL_I) || (state_q == FILL_D);
  // Extra valids past the last word never reach here: the state is IDLE then.
  assign fill_hit  = in_fill && mem.mem_data_valid;
  assign issue_off = {{(15 - WW){1'b0}}, ic_q[WW-1:0], 1'b0};

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DRAIN;
      ic_q    <= '0;
      rc_q    <= '0;
      dc_q    <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      ic_q    <= ic_d;
      rc_q    <= rc_d;
      dc_q    <= dc_d;
      base_q  <= base_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ic_d    = ic_q;
    rc_d    = rc_q;
    dc_d    = dc_q;
    base_d  = base_q;

    unique case (state_q)
      // Waits out reads that were in flight when reset hit; their data
      // returns here and is dropped.
      DRAIN: begin
        if (dc_q == DRAIN_LAST) begin
          state_d = IDLE;
          dc_d    = '0;
        end else begin
          dc_d = dc_q + 1'b1;
        end
      end

      IDLE: begin
        ic_d = '0;
        rc_d = '0;
        if (d_wr_req) begin
          state_d = WRITE;
        end else if (d_miss) begin
          state_d = FILL_D;
          base_d  = d_miss_addr & BLK_MASK;
        end else if (i_miss) begin
          state_d = FILL_I;
          base_d  = i_miss_addr & BLK_MASK;
        end
      end

      WRITE: state_d = IDLE;

      FILL_I, FILL_D: begin
        if (ic_q != ISSUE_END) begin
          ic_d = ic_q + 1'b1;
        end
        if (mem.mem_data_valid) begin
          if (rc_q == LAST_WORD) begin
            state_d = IDLE;
            ic_d    = '0;
            rc_d    = '0;
          end else begin
            rc_d = rc_q + 1'b1;
          end
        end
      end

      default: state_d = DRAIN;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    mem.mem_en    = 1'b0;
    mem.mem_wr    = 1'b0;
    mem.mem_addr  = 16'h0000;
    mem.mem_wdata = 16'h0000;
    i_fill_we     = 1'b0;
    d_fill_we     = 1'b0;
    fill_word     = 3'd0;
    fill_data     = 16'h0000;
    i_tag_we      = 1'b0;
    d_tag_we      = 1'b0;
    d_wr_ack      = 1'b0;

    if (state_q == WRITE) begin
      mem.mem_en    = 1'b1;
      mem.mem_wr    = 1'b1;
      mem.mem_addr  = d_wr_addr;
      mem.mem_wdata = d_wr_data;
      d_wr_ack      = 1'b1;
    end

    if (in_fill && (ic_q != ISSUE_END)) begin
      mem.mem_en   = 1'b1;
      mem.mem_addr = base_q | issue_off;
    end

    if (fill_hit) begin
      i_fill_we = (state_q == FILL_I);
      d_fill_we = (state_q == FILL_D);
      fill_word = 3'(rc_q);
      fill_data = mem.mem_rdata;
      if (rc_q == LAST_WORD) begin
        i_tag_we = (state_q == FILL_I);
        d_tag_we = (state_q == FILL_D);
      end
    end

    // Stalls are combinational on the request inputs, so they are gated by
    // rst_n to keep every output low during reset.
    i_stall = rst_n & i_miss & ~i_tag_we;
    d_stall = rst_n & ((d_miss & ~d_tag_we) | (d_wr_req & ~d_wr_ack));
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Bench for mem_arbiter: a pipelined memory model with fixed read latency, a
// transaction-level reference that plans each grant from the arbitration and
// timing rules into a per-cycle table of expected outputs, and a directed
// plus randomized stimulus sequence.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int L    = 4;
  localparam int W    = 8;
  localparam int MAXC = 6000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_miss = 1'b0;
  logic [15:0] i_miss_addr = 16'h0;
  logic        d_miss = 1'b0;
  logic [15:0] d_miss_addr = 16'h0;
  logic        d_wr_req = 1'b0;
  logic [15:0] d_wr_addr = 16'h0;
  logic [15:0] d_wr_data = 16'h0;
  logic        i_fill_we, d_fill_we;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        i_tag_we, d_tag_we, i_stall, d_stall, d_wr_ack;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  mem_arbiter_if mem_bus ();

  mem_arbiter #(.MEM_LATENCY(L), .WORDS(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_miss      (i_miss),
    .i_miss_addr (i_miss_addr),
    .d_miss      (d_miss),
    .d_miss_addr (d_miss_addr),
    .d_wr_req    (d_wr_req),
    .d_wr_addr   (d_wr_addr),
    .d_wr_data   (d_wr_data),
    .mem         (mem_bus),
    .i_fill_we   (i_fill_we),
    .d_fill_we   (d_fill_we),
    .fill_word   (fill_word),
    .fill_data   (fill_data),
    .i_tag_we    (i_tag_we),
    .d_tag_we    (d_tag_we),
    .i_stall     (i_stall),
    .d_stall     (d_stall),
    .d_wr_ack    (d_wr_ack)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model: contents are a hash of the address -------
  logic [15:0] salt = 16'h0;
  bit          pv [L];
  logic [15:0] pa [L];
  bit          spur = 1'b0;   // forces a spurious valid pulse

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return (a * 16'h9E37) ^ salt;
  endfunction

  always @(posedge clk) begin
    pv[0] <= mem_bus.mem_en & ~mem_bus.mem_wr;
    pa[0] <= mem_bus.mem_addr;
    for (int k = 1; k < L; k++) begin
      pv[k] <= pv[k-1];
      pa[k] <= pa[k-1];
    end
  end

  assign mem_bus.mem_data_valid = pv[L-1] | spur;
  assign mem_bus.mem_rdata      = pv[L-1] ? ((pa[L-1] * 16'h9E37) ^ salt) : 16'hDEAD;

  // ---------------- reference model ----------------------------------------
  typedef struct packed {
    bit        en;
    bit        wr;
    bit [15:0] addr;
    bit [15:0] wdata;
    bit        ife;
    bit        dfe;
    bit [2:0]  word;
    bit [15:0] data;
    bit        itag;
    bit        dtag;
    bit        ack;
  } exp_t;

  exp_t sched [MAXC];
  int   busy_until = MAXC;
  bit   prev_rst = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
    end
  endtask

  // Decide the grant in idle cycle c and lay out its whole transaction:
  // a grant seen at the end of cycle c issues reads in c+1..c+W, returns
  // words in c+1+L..c+W+L, tags in c+W+L and is idle again in c+W+L+1.
  task automatic plan(input int c);
    logic [15:0] base;
    bit          to_d;
    if (d_wr_req) begin
      sched[c+1].en    = 1'b1;
      sched[c+1].wr    = 1'b1;
      sched[c+1].addr  = d_wr_addr;
      sched[c+1].wdata = d_wr_data;
      sched[c+1].ack   = 1'b1;
      busy_until = c + 2;
    end else if (d_miss || i_miss) begin
      to_d = d_miss;
      base = (to_d ? d_miss_addr : i_miss_addr) & 16'hFFF0;
      for (int k = 0; k < W; k++) begin
        sched[c+1+k].en       = 1'b1;
        sched[c+1+k].addr     = base + 16'(2 * k);
        sched[c+1+L+k].ife    = !to_d;
        sched[c+1+L+k].dfe    = to_d;
        sched[c+1+L+k].word   = 3'(k);
        sched[c+1+L+k].data   = mdata(base + 16'(2 * k));
      end
      sched[c+W+L].itag = !to_d;
      sched[c+W+L].dtag = to_d;
      busy_until = c + W + L + 1;
    end
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [1:0] st;
    e = rst_n ? sched[cyc] : '0;
    chk("mem_ctl", 64'({mem_bus.mem_en, mem_bus.mem_wr}), 64'({e.en, e.wr}));
    if (!rst_n || e.en) chk("mem_addr", 64'(mem_bus.mem_addr), 64'(e.addr));
    if (!rst_n || e.wr) chk("mem_wdata", 64'(mem_bus.mem_wdata), 64'(e.wdata));
    chk("fill", 64'({i_fill_we, d_fill_we, fill_word, fill_data}),
                64'({e.ife, e.dfe, e.word, e.data}));
    chk("tag_ack", 64'({i_tag_we, d_tag_we, d_wr_ack}), 64'({e.itag, e.dtag, e.ack}));
    st = rst_n ? {i_miss & ~e.itag, (d_miss & ~e.dtag) | (d_wr_req & ~e.ack)} : 2'b00;
    chk("stall", 64'({i_stall, d_stall}), 64'(st));
    if (!rst_n) begin
      for (int k = cyc + 1; k < MAXC; k++) sched[k] = '0;
      busy_until = MAXC;
    end else begin
      // Release happens just after a falling edge; the DRAIN window covers
      // that cycle and the next three, so the first idle cycle is cyc+3.
      if (!prev_rst) busy_until = cyc + 3;
      if (cyc >= busy_until && cyc + L + W + 4 < MAXC) plan(cyc);
    end
    prev_rst = rst_n;
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic serve(input bit ri, input bit rd, input bit rw,
                       input logic [15:0] ai, input logic [15:0] ad,
                       input logic [15:0] aw, input logic [15:0] wd,
                       input int drop_i);
    bit pi, pd, pw;
    int n;
    @(posedge clk); #1;
    spur = 1'b0;
    i_miss = ri; i_miss_addr = ai;
    d_miss = rd; d_miss_addr = ad;
    d_wr_req = rw; d_wr_addr = aw; d_wr_data = wd;
    pi = ri; pd = rd; pw = rw; n = 0;
    while ((pi || pd || pw) && n < 200) begin
      @(negedge clk);
      if (i_tag_we) pi = 1'b0;
      if (d_tag_we) pd = 1'b0;
      if (d_wr_ack) pw = 1'b0;
      @(posedge clk); #1;
      n++;
      if (!pi || (drop_i > 0 && n >= drop_i)) i_miss = 1'b0;
      if (!pd) d_miss = 1'b0;
      if (!pw) d_wr_req = 1'b0;
    end
    chk("serve_done", 64'({pi, pd, pw}), 64'(0));
  endtask

  initial begin
    int cnt, n;
    bit [2:0] kind;
    salt = 16'($urandom);

    // Reset with requests already pending: everything must stay low.
    i_miss = 1'b1; i_miss_addr = 16'h1236;
    d_wr_req = 1'b1; d_wr_addr = 16'h7777; d_wr_data = 16'h5555;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    d_wr_req = 1'b0;
    rst_n = 1'b1;

    // I fill of 0x1236 granted after DRAIN.
    serve(1'b1, 1'b0, 1'b0, 16'h1236, 16'h0, 16'h0, 16'h0, 0);

    // Simultaneous D and I misses: D first, then I.
    serve(1'b1, 1'b1, 1'b0, 16'h0010, 16'h4008, 16'h0, 16'h0, 0);

    // Store together with an I miss: WRITE cycle first.
    serve(1'b1, 1'b0, 1'b1, 16'h2A5C, 16'h0, 16'h8002, 16'hBEEF, 0);

    // Reset after three returned words.
    @(posedge clk); #1;
    i_miss = 1'b1; i_miss_addr = 16'h3334;
    cnt = 0; n = 0;
    while (cnt < 3 && n < 100) begin
      @(negedge clk);
      if (i_fill_we) cnt++;
      n++;
    end
    chk("words_before_reset", 64'(cnt), 64'(3));
    #1 rst_n = 1'b0;
    @(posedge clk); #1 spur = 1'b1;
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 spur = 1'b1;
    @(posedge clk); #1 spur = 1'b0;
    serve(1'b1, 1'b0, 1'b0, 16'h3334, 16'h0, 16'h0, 16'h0, 0);

    // Spurious valids in IDLE, then an I miss dropped mid-fill.
    @(posedge clk); #1 spur = 1'b1;
    @(posedge clk); @(posedge clk); #1 spur = 1'b0;
    serve(1'b1, 1'b0, 1'b0, 16'($urandom), 16'h0, 16'h0, 16'h0, 3);

    // Randomized mixes of requests with idle gaps and stray valids.
    for (int t = 0; t < 30; t++) begin
      kind = 3'($urandom_range(1, 7));
      serve(kind[2], kind[1], kind[0], 16'($urandom), 16'($urandom),
            16'($urandom), 16'($urandom),
            (kind == 3'b100 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 10)) : 0);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1 spur = bit'($urandom_range(0, 1));
      end
      @(posedge clk); #1 spur = 1'b0;
    end

    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
